// File: rtl/tick_sched.sv
// ---------------------------------------------------------------------------
// tick_sched
//   Multi-channel game-timing scheduler. One shared prescaler produces a
//   base_tick pulse at BASE_HZ. Each of NCH channels counts base_ticks and
//   emits a one-cycle tick[i] every div[i] base_ticks. All outputs are
//   clock enables in the clk domain; nothing here generates a derived clock.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   run        1 = prescaler advances, 0 = pause (all counters hold)
//   ch_en      per-channel enable; dropping it discards partial progress
//   cfg_we     single-cycle config write strobe
//   cfg_ch     channel index for the write (out-of-range writes are ignored)
//   cfg_div    new period in base ticks, 0 = channel silent
//   cfg_ack    one-cycle acknowledge of an accepted write
//   base_tick  one-cycle pulse at BASE_HZ while running
//   tick       one-cycle pulse per channel
// ---------------------------------------------------------------------------
module tick_sched #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BASE_HZ     = 1000,
  parameter int NCH         = 4,
  parameter int DIVW        = 16,
  parameter int DEFAULT_DIV = 100,
  localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [NCH-1:0]  ch_en,
  input  logic            cfg_we,
  input  logic [CW-1:0]   cfg_ch,
  input  logic [DIVW-1:0] cfg_div,
  output logic            cfg_ack,
  output logic            base_tick,
  output logic [NCH-1:0]  tick
);

  localparam int PRE = CLK_HZ / BASE_HZ;
  localparam int PW  = $clog2(PRE);

  localparam logic [PW-1:0]   PCNT_MAX = PW'(PRE - 1);
  localparam logic [DIVW-1:0] DEF_DIV  = DIVW'(DEFAULT_DIV);
  localparam logic [DIVW-1:0] DEF_CNT  = DIVW'(DEFAULT_DIV - 1);

  logic [PW-1:0] pcnt;
  logic          cfg_valid;

  // Countdown reload value for a period: div-1, but a silent channel (div=0)
  // parks at zero instead of wrapping to all-ones.
  function automatic logic [DIVW-1:0] reload(input logic [DIVW-1:0] d);
    return (d == '0) ? '0 : d - DIVW'(1);
  endfunction

  // Shared prescaler. base_tick is registered so it is exactly one clk wide,
  // and pausing holds pcnt so resuming neither adds nor drops a base tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt      <= '0;
      base_tick <= 1'b0;
    end else if (run) begin
      if (pcnt == PCNT_MAX) begin
        pcnt      <= '0;
        base_tick <= 1'b1;
      end else begin
        pcnt      <= pcnt + PW'(1);
        base_tick <= 1'b0;
      end
    end else begin
      base_tick <= 1'b0;
    end
  end

  // When NCH fills the whole index space every index is a real channel;
  // otherwise indices at or above NCH must not be acknowledged.
  generate
    if (NCH == (1 << CW)) begin : g_full_index
      assign cfg_valid = 1'b1;
    end else begin : g_part_index
      assign cfg_valid = (cfg_ch < CW'(NCH));
    end
  endgenerate

  // Acknowledge follows each accepted write by one cycle, so back-to-back
  // writes produce back-to-back acks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ack <= 1'b0;
    end else begin
      cfg_ack <= cfg_we & cfg_valid;
    end
  end

  // Per-channel period register and countdown. Priority: a config write wins
  // over everything (even a coincident base_tick), then a disabled or silent
  // channel is held at its full reload value, then the base tick counts down.
  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [DIVW-1:0] div;
      logic [DIVW-1:0] cnt;
      logic            tick_q;
      logic            hit;

      assign hit     = cfg_we & (cfg_ch == CW'(i));
      assign tick[i] = tick_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          div    <= DEF_DIV;
          cnt    <= DEF_CNT;
          tick_q <= 1'b0;
        end else if (hit) begin
          div    <= cfg_div;
          cnt    <= reload(cfg_div);
          tick_q <= 1'b0;
        end else if (!ch_en[i] || (div == '0)) begin
          cnt    <= reload(div);
          tick_q <= 1'b0;
        end else if (base_tick) begin
          if (cnt == '0) begin
            cnt    <= reload(div);
            tick_q <= 1'b1;
          end else begin
            cnt    <= cnt - DIVW'(1);
            tick_q <= 1'b0;
          end
        end else begin
          tick_q <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_tick_sched.sv
// ---------------------------------------------------------------------------
// tb_tick_sched
//   Self-checking bench for tick_sched (CLK_HZ=20, BASE_HZ=5 -> PRE=4,
//   NCH=4, DIVW=8, DEFAULT_DIV=3). A second instance with NCH=6 exercises
//   out-of-range channel writes. A behavioural model counts run edges and
//   consumed base ticks per channel; a compare process checks every cycle,
//   and directed scenarios pin exact pulse positions with literal values.
// ---------------------------------------------------------------------------
module tb_tick_sched;

  localparam int PRE = 4;
  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [3:0] ch_en = 4'h0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = 2'd0;
  logic [7:0] cfg_div = 8'd0;
  logic [2:0] cfg_ch6 = 3'd0;
  logic [5:0] ch_en6 = 6'h3F;

  logic       cfg_ack, base_tick;
  logic [3:0] tick;
  logic       cfg_ack6, base_tick6;
  logic [5:0] tick6;

  int vectors = 0;
  int miscompares = 0;

  tick_sched #(.CLK_HZ(20), .BASE_HZ(5), .NCH(4), .DIVW(8), .DEFAULT_DIV(3)) u_dut (
    .clk(clk), .rst(rst), .run(run), .ch_en(ch_en), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_ack(cfg_ack),
    .base_tick(base_tick), .tick(tick)
  );

  tick_sched #(.CLK_HZ(20), .BASE_HZ(5), .NCH(6), .DIVW(8), .DEFAULT_DIV(3)) u_dut6 (
    .clk(clk), .rst(rst), .run(run), .ch_en(ch_en6), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch6), .cfg_div(cfg_div), .cfg_ack(cfg_ack6),
    .base_tick(base_tick6), .tick(tick6)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Behavioural model: base ticks come from counting run edges since reset;
  // each channel counts base ticks consumed since its last restart and fires
  // whenever that count is a multiple of its period.
  int       run_count;
  bit       exp_base;
  bit       exp_ack;
  bit       exp_ack6;
  bit [3:0] exp_tick;
  int       mdiv [NCH];
  int       seen [NCH];
  bit       prev_base;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      run_count = 0;
      exp_base  = 1'b0;
      exp_ack   = 1'b0;
      exp_ack6  = 1'b0;
      exp_tick  = '0;
      for (int i = 0; i < NCH; i++) begin
        mdiv[i] = 3;
        seen[i] = 0;
      end
    end else begin
      prev_base = exp_base;
      for (int i = 0; i < NCH; i++) begin
        if (cfg_we && int'(cfg_ch) == i) begin
          mdiv[i]     = int'(cfg_div);
          seen[i]     = 0;
          exp_tick[i] = 1'b0;
        end else if (!ch_en[i] || mdiv[i] == 0) begin
          seen[i]     = 0;
          exp_tick[i] = 1'b0;
        end else if (prev_base) begin
          seen[i]     = seen[i] + 1;
          exp_tick[i] = (seen[i] % mdiv[i]) == 0;
        end else begin
          exp_tick[i] = 1'b0;
        end
      end
      if (run) begin
        run_count = run_count + 1;
        exp_base  = (run_count % PRE) == 0;
      end else begin
        exp_base = 1'b0;
      end
      exp_ack  = cfg_we;
      exp_ack6 = cfg_we && (int'(cfg_ch6) < 6);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, away from the active edge, compare against the model.
  always @(negedge clk) begin
    checkOutput("model_base_tick", int'(base_tick), int'(exp_base));
    checkOutput("model_tick", int'(tick), int'(exp_tick));
    checkOutput("model_cfg_ack", int'(cfg_ack), int'(exp_ack));
    checkOutput("model_cfg_ack6", int'(cfg_ack6), int'(exp_ack6));
  end

  task automatic applyStimulus(input logic r, input logic [3:0] en, input logic we,
                               input logic [1:0] ch, input logic [7:0] dv,
                               input logic [2:0] ch6);
    run     = r;
    ch_en   = en;
    cfg_we  = we;
    cfg_ch  = ch;
    cfg_div = dv;
    cfg_ch6 = ch6;
  endtask

  // Holds reset across two edges and releases it 1 unit after an edge, so
  // the next rising edge is edge 1.
  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 8'd0, 3'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Directed scenarios with hand-computed pulse positions (edge n = n-th
  // edge after reset release, outputs sampled 2 units after that edge).
  task automatic directedRun(input int mode, input int n_edges);
    logic       r;
    logic [3:0] en;
    logic       we;
    logic [1:0] ch;
    logic [7:0] dv;
    logic       eb, ea;
    logic [3:0] et;
    logic [5:0] et6;
    doReset();
    checkOutput("reset_base_tick", int'(base_tick), 0);
    checkOutput("reset_tick", int'(tick), 0);
    checkOutput("reset_cfg_ack", int'(cfg_ack), 0);
    for (int n = 1; n <= n_edges; n++) begin
      r = 1'b1; en = 4'hF; we = 1'b0; ch = 2'd0; dv = 8'd0;
      case (mode)
        2: begin we = (n == 2); ch = 2'd1; dv = 8'd1; end
        3: begin we = (n == 13); ch = 2'd0; dv = 8'd2; end
        4: r = !(n >= 3 && n <= 12);
        5: begin we = (n == 1); ch = 2'd2; dv = 8'd0; en = (n <= 20) ? 4'h7 : 4'hF; end
        default: ;
      endcase
      applyStimulus(r, en, we, ch, dv, 3'd7);
      @(posedge clk);
      #2;
      eb = (n % 4) == 0;
      ea = 1'b0;
      et = 4'h0;
      et6 = (n == 13 || n == 25) ? 6'h3F : 6'h00;
      case (mode)
        1: if (n == 13 || n == 25) et = 4'hF;
        2: begin
          ea = (n == 2);
          if (n == 13 || n == 25) et = 4'hD;
          if (n >= 5 && (n % 4) == 1) et = et | 4'h2;
        end
        3: begin
          ea = (n == 13);
          if (n == 13 || n == 25) et = 4'hE;
          if (n == 21) et = 4'h1;
        end
        4: begin
          eb  = (n >= 14) && (((n - 14) % 4) == 0);
          et  = (n == 23) ? 4'hF : 4'h0;
          et6 = (n == 23) ? 6'h3F : 6'h00;
        end
        5: begin
          ea = (n == 1);
          if (n == 13 || n == 25) et = 4'h3;
          if (n == 29) et = 4'h8;
        end
        default: ;
      endcase
      checkOutput($sformatf("m%0d_e%0d_base_tick", mode, n), int'(base_tick), int'(eb));
      checkOutput($sformatf("m%0d_e%0d_tick", mode, n), int'(tick), int'(et));
      checkOutput($sformatf("m%0d_e%0d_cfg_ack", mode, n), int'(cfg_ack), int'(ea));
      checkOutput($sformatf("m%0d_e%0d_cfg_ack6", mode, n), int'(cfg_ack6), 0);
      checkOutput($sformatf("m%0d_e%0d_tick6", mode, n), int'(tick6), int'(et6));
    end
  endtask

  initial begin
    logic       r;
    logic [3:0] en;
    logic       we;
    logic [1:0] ch;
    logic [7:0] dv;
    logic [2:0] ch6;
    int         pick;

    directedRun(1, 26);
    directedRun(2, 14);
    directedRun(3, 26);
    directedRun(4, 24);
    directedRun(5, 30);

    // Asynchronous reset between edges while all ticks are high.
    directedRun(1, 13);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_tick", int'(tick), 0);
    checkOutput("async_rst_base_tick", int'(base_tick), 0);
    checkOutput("async_rst_cfg_ack", int'(cfg_ack), 0);
    directedRun(1, 26);

    // Randomized traffic checked by the model.
    en = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 199) == 0);
      r   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) en = 4'($urandom);
      we  = ($urandom_range(0, 4) == 0);
      ch  = 2'($urandom);
      ch6 = 3'($urandom);
      pick = $urandom_range(0, 9);
      if (pick == 0) dv = 8'd0;
      else if (pick < 8) dv = 8'($urandom_range(1, 4));
      else dv = 8'($urandom_range(5, 255));
      applyStimulus(r, en, we, ch, dv, ch6);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b1, 4'hF, 1'b0, 2'd0, 8'd0, 3'd0);
    repeat (4) @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
